// File: rtl/psk_symbol_mapper.sv
// psk_symbol_mapper
//   Takes one N-bit codeword over a valid/ready handshake. It serialises the
//   codeword MSB-first into BPSK (1 bit/symbol) or QPSK (2 bits/symbol)
//   symbols. Optional Flag inversion and differential encoding are applied.
//   Symbols are emitted as signed I/Q amplitudes, and the downstream side
//   can apply backpressure.
//
// Ports
//   CLK       rising-edge clock
//   RSTn      synchronous, active-low reset
//   DataIn    codeword, bit N-1 goes out first
//   InValid   DataIn/Mode/Diff/Flag valid
//   InReady   block can accept a codeword (registered)
//   Mode      0 = BPSK, 1 = QPSK
//   Diff      1 = differential encoding
//   Flag      1 = invert every data bit
//   SymI      signed in-phase amplitude (0 when no symbol is presented)
//   SymQ      signed quadrature amplitude (0 in BPSK or when idle)
//   SymValid  symbol outputs valid
//   SymReady  downstream accepts the current symbol
//   SymLast   current symbol is the last of the codeword
//   Busy      a codeword is being serialised
module psk_symbol_mapper #(
  parameter int N     = 12,
  parameter int AMP_W = 8,
  parameter int AMP   = 127
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic [N-1:0]            DataIn,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic                    Mode,
  input  logic                    Diff,
  input  logic                    Flag,
  output logic signed [AMP_W-1:0] SymI,
  output logic signed [AMP_W-1:0] SymQ,
  output logic                    SymValid,
  input  logic                    SymReady,
  output logic                    SymLast,
  output logic                    Busy
);

  localparam int CNT_W = $clog2(N + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic signed [AMP_W-1:0] POS = AMP_W'(AMP);
  localparam logic signed [AMP_W-1:0] NEG = AMP_W'(-AMP);

  // Index of the final symbol; the counter runs down to zero.
  localparam logic [CNT_W-1:0] LAST_B = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_Q = CNT_W'((N + 1) / 2 - 1);

  logic [0:0]             state_reg;
  logic                   in_ready_reg;
  logic                   mode_reg;
  logic                   diff_reg;
  logic                   flag_reg;
  // The current symbol's bit(s) are held at the top of the register. One
  // extra zero bit at the bottom supplies the QPSK pad for odd N.
  logic [N:0]             bits_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   ref_i_reg;
  logic                   ref_q_reg;
  // Differential outputs of the symbol currently presented. They become the
  // new references when that symbol is accepted.
  logic                   d_i_reg;
  logic                   d_q_reg;
  logic signed [AMP_W-1:0] sym_i_reg;
  logic signed [AMP_W-1:0] sym_q_reg;
  logic                   sym_last_reg;

  logic [N:0]             src_bits_next;
  logic                   src_mode_next;
  logic                   src_diff_next;
  logic                   src_flag_next;
  logic                   src_ref_i_next;
  logic                   src_ref_q_next;
  logic                   d_i_next;
  logic                   d_q_next;
  logic signed [AMP_W-1:0] sym_i_next;
  logic signed [AMP_W-1:0] sym_q_next;
  logic [CNT_W-1:0]       init_cnt_next;

  // Compute the symbol to present next. In IDLE this is the first symbol of
  // the incoming word. In SEND it is the symbol after the one now on the
  // outputs, and it uses the references as they stand after that symbol is
  // accepted.
  always_comb begin
    src_bits_next  = {DataIn, 1'b0};
    src_mode_next  = Mode;
    src_diff_next  = Diff;
    src_flag_next  = Flag;
    src_ref_i_next = ref_i_reg;
    src_ref_q_next = ref_q_reg;
    if (state_reg == SEND) begin
      src_bits_next  = mode_reg ? (bits_reg << 2) : (bits_reg << 1);
      src_mode_next  = mode_reg;
      src_diff_next  = diff_reg;
      src_flag_next  = flag_reg;
      src_ref_i_next = diff_reg ? d_i_reg : ref_i_reg;
      src_ref_q_next = (diff_reg && mode_reg) ? d_q_reg : ref_q_reg;
    end
    d_i_next      = src_bits_next[N]   ^ src_flag_next ^ (src_diff_next & src_ref_i_next);
    d_q_next      = src_bits_next[N-1] ^ src_flag_next ^ (src_diff_next & src_ref_q_next);
    sym_i_next    = d_i_next ? NEG : POS;
    sym_q_next    = src_mode_next ? (d_q_next ? NEG : POS) : '0;
    init_cnt_next = Mode ? LAST_Q : LAST_B;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_reg    <= IDLE;
      in_ready_reg <= 1'b0;
      mode_reg     <= 1'b0;
      diff_reg     <= 1'b0;
      flag_reg     <= 1'b0;
      bits_reg     <= '0;
      cnt_reg      <= '0;
      ref_i_reg    <= 1'b0;
      ref_q_reg    <= 1'b0;
      d_i_reg      <= 1'b0;
      d_q_reg      <= 1'b0;
      sym_i_reg    <= '0;
      sym_q_reg    <= '0;
      sym_last_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (InValid && in_ready_reg) begin
            state_reg    <= SEND;
            in_ready_reg <= 1'b0;
            mode_reg     <= Mode;
            diff_reg     <= Diff;
            flag_reg     <= Flag;
            bits_reg     <= src_bits_next;
            cnt_reg      <= init_cnt_next;
            d_i_reg      <= d_i_next;
            d_q_reg      <= d_q_next;
            sym_i_reg    <= sym_i_next;
            sym_q_reg    <= sym_q_next;
            sym_last_reg <= (init_cnt_next == '0);
          end
        end
        default: begin
          if (SymReady) begin
            if (diff_reg) begin
              ref_i_reg <= d_i_reg;
              if (mode_reg) ref_q_reg <= d_q_reg;
            end
            if (sym_last_reg) begin
              state_reg    <= IDLE;
              in_ready_reg <= 1'b1;
              sym_i_reg    <= '0;
              sym_q_reg    <= '0;
              sym_last_reg <= 1'b0;
            end else begin
              bits_reg     <= src_bits_next;
              cnt_reg      <= cnt_reg - 1'b1;
              d_i_reg      <= d_i_next;
              d_q_reg      <= d_q_next;
              sym_i_reg    <= sym_i_next;
              sym_q_reg    <= sym_q_next;
              sym_last_reg <= (cnt_reg == CNT_W'(1));
            end
          end
        end
      endcase
    end
  end

  assign InReady  = in_ready_reg;
  assign Busy     = (state_reg == SEND);
  assign SymValid = (state_reg == SEND);
  assign SymI     = sym_i_reg;
  assign SymQ     = sym_q_reg;
  assign SymLast  = sym_last_reg;

endmodule

// File: doc/psk_symbol_mapper.md
Name: psk_symbol_mapper

Overview:
Parametrised successor to the fixed-width BPSK inverter stage. It accepts one N-bit codeword from the Hamming or BCH encoder over a valid/ready handshake and serialises it MSB-first into BPSK or QPSK symbols. It supports optional differential encoding and the existing Flag bit-inversion. Symbols are emitted as signed I/Q amplitude pairs, with backpressure, to the channel/noise stage.

Parameters:
N, 12, codeword width in bits (12 for Hamming, 15 for BCH; legal range 2..32).
AMP_W, 8, width of the signed SymI/SymQ outputs.
AMP, 127, symbol magnitude; must be > 0 and < 2^(AMP_W-1).

Ports:
CLK  in  1  clock; all logic on the rising edge.
RSTn  in  1  reset; synchronous, active-low.
DataIn  in  N  codeword; bit N-1 is transmitted first.
InValid  in  1  DataIn, Mode, Diff and Flag are valid.
InReady  out  1  block can accept a codeword.
Mode  in  1  0 = BPSK (1 bit/symbol), 1 = QPSK (2 bits/symbol).
Diff  in  1  1 = differential encoding enabled.
Flag  in  1  1 = invert every data bit before mapping.
SymI  out  AMP_W  signed in-phase amplitude.
SymQ  out  AMP_W  signed quadrature amplitude.
SymValid  out  1  SymI/SymQ/SymLast are valid.
SymReady  in  1  downstream accepts the current symbol.
SymLast  out  1  current symbol is the last of the codeword.
Busy  out  1  a codeword is being serialised.

Behaviour:
- Reset (RSTn=0 at a rising edge):
  - state=IDLE; InReady=0 during reset, 1 from the first edge with RSTn=1.
  - SymValid=0, SymLast=0, SymI=0, SymQ=0, Busy=0.
  - Differential references refI=refQ=0.
  - Reset mid-word aborts the word; no further symbols of that word are emitted.
- States:
  - IDLE: InReady=1, Busy=0, SymValid=0.
  - SEND: InReady=0, Busy=1, SymValid=1.
- IDLE->SEND when InValid&&InReady at an edge.
  - DataIn, Mode, Diff and Flag are latched at that edge.
  - Input changes during SEND are ignored.
- Latency: accept at edge k; first symbol valid after edge k (visible in cycle k+1).
- Symbol advance: only on an edge with SymValid&&SymReady.
  - While SymReady=0, SymI, SymQ and SymLast hold stable.
- Symbol count: BPSK = N; QPSK = ceil(N/2).
  - For odd N in QPSK, the final pair is {bit0, 0}; the pad bit is also subject to Flag/Diff.
- Bit processing per bit b: b' = b ^ Flag.
  - Diff=1, BPSK: d = b' ^ refI; refI <= d once the symbol is accepted.
  - Diff=1, QPSK: first bit of the pair uses refI, second uses refQ; each updates on acceptance.
  - Diff=0: d = b'; references are left unchanged.
  - References persist across codewords; they are cleared only by reset.
- Mapping: bit 0 -> +AMP, bit 1 -> -AMP.
  - BPSK: I from d, SymQ=0.
  - QPSK: I from the first (more significant) bit, Q from the second bit.
- SymLast=1 only on the final symbol.
  - Acceptance of the final symbol -> IDLE; InReady=1 on the next cycle (one idle cycle between words).
- SymI/SymQ are 0 whenever SymValid=0.
- All outputs are registered; no combinational path from SymReady or InValid to any output.

Test Plan:
1. N=12, BPSK, Flag=0, Diff=0, DataIn=12'hA5C, SymReady=1 -> SymI = -127,+127,-127,+127,+127,-127,+127,-127,-127,-127,+127,+127; SymQ=0; SymLast only on symbol 12; InReady=1 one cycle after.
2. Same word with Flag=1 -> every SymI sign inverted; then QPSK, Flag=0 -> (I,Q) = (-,+),(-,+),(+,-),(+,-),(-,-),(+,+) × 127; 6 symbols.
3. BPSK, Diff=1, first word after reset, DataIn=12'hA5C -> d = 1,1,0,0,0,1,1,0,1,0,0,0; SymI signs follow (-,-,+,+,+,-,-,+,-,+,+,+); a following word continues from refI=0.
4. Backpressure: SymReady=0 for 3 cycles while symbol 2 is presented -> SymI/SymQ/SymLast unchanged; total 12 accepted symbols, none dropped or duplicated; InValid pulses during SEND are ignored.
5. N=15, QPSK, DataIn=15'h7FFF -> 8 symbols; first 7 are (-127,-127); 8th is (-127,+127) with SymLast=1.
6. RSTn=0 for one edge during symbol 5 -> next cycle SymValid=0, SymI=SymQ=0, Busy=0; InReady=1 once RSTn=1; a new word starts from symbol 1 with refI=refQ=0.
